// File: rtl/stoch_pkg.sv
// Shared types and sizing helpers for the stochastic bitstream generator.
package stoch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stoch_state_t;

    // Counters must hold the value STREAM_LEN itself, hence the +1.
    function automatic int cnt_width(input int stream_len);
        return $clog2(stream_len + 1);
    endfunction

endpackage

// File: rtl/serial_word_collector.sv
// Assembles WIDTH serial random bits into one word, earliest-sampled bit as MSB.
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             r,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] word,
    output logic             word_ready
);

    localparam int BC_W = $clog2(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    logic [WIDTH-2:0] rand_sr_q, rand_sr_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;

    assign word       = {rand_sr_q, r};
    assign word_ready = enable && (bit_cnt_q == LAST_BIT);

    always_comb begin
        rand_sr_d = (WIDTH-1)'({rand_sr_q, r});
        bit_cnt_d = bit_cnt_q;
        if (clear) begin
            bit_cnt_d = '0;
        end else if (enable) begin
            bit_cnt_d = word_ready ? '0 : bit_cnt_q + BC_W'(1);
        end
    end

    // The shift register runs in every state so a word is always primed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rand_sr_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            rand_sr_q <= rand_sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/stochastic_bitstream_gen.sv
// Compares random words against a latched probability, emitting one stochastic bit per word.
module stochastic_bitstream_gen
    import stoch_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STREAM_LEN = 256,
    parameter int CNT_W      = cnt_width(STREAM_LEN)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             r,
    input  logic             start,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_load,
    output logic             sbit,
    output logic             sbit_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ones_count,
    output stoch_state_t     dbg_state
);

    localparam logic [CNT_W-1:0] LAST_EMIT = CNT_W'(STREAM_LEN - 1);

    stoch_state_t     state_q, state_d;
    logic [WIDTH-1:0] p_active_q, p_active_d;
    logic [WIDTH-1:0] p_shadow_q, p_shadow_d;
    logic             pending_q, pending_d;
    logic             sbit_q, sbit_d;
    logic             sbit_valid_q, sbit_valid_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] emit_q, emit_d;

    logic             start_acc;
    logic             in_run;
    logic [WIDTH-1:0] word;
    logic             word_ready;
    logic             cmp;

    assign in_run    = (state_q == RUN);
    assign start_acc = start && !in_run;
    assign cmp       = (word < p_active_q);

    serial_word_collector #(.WIDTH(WIDTH)) u_collector (
        .CLK        (CLK),
        .RST        (RST),
        .r          (r),
        .clear      (start_acc),
        .enable     (in_run),
        .word       (word),
        .word_ready (word_ready)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = RUN;
            RUN:        if (word_ready && emit_q == LAST_EMIT) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        p_active_d   = p_active_q;
        p_shadow_d   = p_shadow_q;
        pending_d    = pending_q;
        sbit_d       = sbit_q;
        sbit_valid_d = 1'b0;
        ones_d       = ones_q;
        emit_d       = emit_q;
        if (start_acc) begin
            p_active_d = p_in;
            pending_d  = 1'b0;
            ones_d     = '0;
            emit_d     = '0;
        end else begin
            if (word_ready) begin
                sbit_d       = cmp;
                sbit_valid_d = 1'b1;
                ones_d       = ones_q + (cmp ? CNT_W'(1) : CNT_W'(0));
                emit_d       = emit_q + CNT_W'(1);
            end
            // A new probability only takes effect after the current word's comparison.
            if (p_load) begin
                p_shadow_d = p_in;
                if (word_ready) begin
                    p_active_d = p_in;
                    pending_d  = 1'b0;
                end else if (in_run) begin
                    pending_d  = 1'b1;
                end else begin
                    p_active_d = p_in;
                end
            end else if (word_ready && pending_q) begin
                p_active_d = p_shadow_q;
                pending_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            p_active_q   <= '0;
            p_shadow_q   <= '0;
            pending_q    <= 1'b0;
            sbit_q       <= 1'b0;
            sbit_valid_q <= 1'b0;
            ones_q       <= '0;
            emit_q       <= '0;
        end else begin
            p_active_q   <= p_active_d;
            p_shadow_q   <= p_shadow_d;
            pending_q    <= pending_d;
            sbit_q       <= sbit_d;
            sbit_valid_q <= sbit_valid_d;
            ones_q       <= ones_d;
            emit_q       <= emit_d;
        end
    end

    assign sbit       = sbit_q;
    assign sbit_valid = sbit_valid_q;
    assign busy       = in_run;
    assign done       = (state_q == DONE);
    assign ones_count = ones_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_stochastic_bitstream_gen.sv
// Directed bench for stochastic_bitstream_gen: word-level reference model plus literal expectations.
module tb_stochastic_bitstream_gen;
    import stoch_pkg::*;

    localparam int WIDTH      = 8;
    localparam int STREAM_LEN = 4;
    localparam int CNT_W      = 3;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             r = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] p_in = '0;
    logic             p_load = 1'b0;
    logic             sbit;
    logic             sbit_valid;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_count;
    stoch_state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    bit check_en = 0;
    logic [0:0] exp_q[$];

    always #5 CLK = ~CLK;

    stochastic_bitstream_gen #(.WIDTH(WIDTH), .STREAM_LEN(STREAM_LEN)) dut (
        .CLK(CLK), .RST(RST), .r(r), .start(start), .p_in(p_in), .p_load(p_load),
        .sbit(sbit), .sbit_valid(sbit_valid), .busy(busy), .done(done),
        .ones_count(ones_count), .dbg_state(dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collects raw bits of the run into a queue, forms words arithmetically.
    bit   m_run, m_done, m_pend, m_valid, m_sbit;
    int   m_p, m_shadow, m_ones, m_emit;
    bit   m_bits[$];

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_run = 0; m_done = 0; m_pend = 0; m_valid = 0; m_sbit = 0;
            m_p = 0; m_shadow = 0; m_ones = 0; m_emit = 0;
            m_bits.delete();
        end else begin
            bit was_run;
            bit completing;
            int word;
            m_valid = 0;
            was_run = m_run;
            completing = 0;
            if (start && !m_run) begin
                m_run = 1; m_done = 0; m_p = int'(p_in); m_pend = 0;
                m_ones = 0; m_emit = 0;
                m_bits.delete();
            end else begin
                if (m_run) begin
                    m_bits.push_back(r);
                    if (m_bits.size() == WIDTH) begin
                        word = 0;
                        foreach (m_bits[i]) word = word * 2 + int'(m_bits[i]);
                        m_bits.delete();
                        m_sbit = (word < m_p);
                        m_valid = 1;
                        m_ones += int'(m_sbit);
                        m_emit++;
                        completing = 1;
                        if (m_emit == STREAM_LEN) begin
                            m_run = 0;
                            m_done = 1;
                        end
                    end
                end
                if (p_load) begin
                    m_shadow = int'(p_in);
                    if (completing) begin
                        m_p = int'(p_in);
                        m_pend = 0;
                    end else if (was_run) m_pend = 1;
                    else m_p = int'(p_in);
                end else if (completing && m_pend) begin
                    m_p = m_shadow;
                    m_pend = 0;
                end
            end
        end
    end

    // Every-cycle compare against the model, plus scoreboard pop on each emitted bit.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (check_en) begin
                chk("valid", sbit_valid, m_valid);
                chk("sbit", sbit, m_sbit);
                chk("busy", busy, m_run);
                chk("done", done, m_done);
                chk("ones", ones_count, m_ones);
                if (sbit_valid) begin
                    if (exp_q.size() == 0) chk("sb_extra", 1, 0);
                    else chk("sb_sbit", sbit, exp_q.pop_front());
                end
            end
        end
    end

    // Caller is at a falling edge; start is sampled on the next rising edge.
    task automatic start_run(input logic [WIDTH-1:0] p);
        start = 1; p_in = p; p_load = 0; r = 1'($urandom_range(0, 1));
        @(negedge CLK);
        start = 0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input int load_at,
                             input logic [WIDTH-1:0] load_val, input int start_at);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            r = w[i];
            p_load = (WIDTH - 1 - i == load_at);
            if (p_load) p_in = load_val;
            start = (WIDTH - 1 - i == start_at);
            if (start) p_in = 8'h00;
            @(negedge CLK);
        end
        p_load = 0;
        start = 0;
        chk("valid_lat", sbit_valid, 1);
    endtask

    task automatic push4(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) exp_q.push_back(bits[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            r = 1'($urandom_range(0, 1));
            @(negedge CLK);
        end
    endtask

    initial begin
        RST = 1;
        #12;
        chk("rst_sbit", sbit, 0);
        chk("rst_valid", sbit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ones", ones_count, 0);
        @(negedge CLK);
        RST = 0;
        check_en = 1;
        idle(3);

        // Basic stream at p = 0.5
        push4(4'b1010);
        start_run(8'h80);
        send_word(8'h00, -1, 0, -1);
        send_word(8'hFF, -1, 0, -1);
        send_word(8'h7F, -1, 0, -1);
        send_word(8'h80, -1, 0, -1);
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_ones", ones_count, 2);
        idle(4);
        chk("t1_hold_ones", ones_count, 2);

        // p = 0 with random words
        push4(4'b0000);
        start_run(8'h00);
        for (int k = 0; k < 4; k++) send_word(8'($urandom_range(0, 255)), -1, 0, -1);
        chk("t2_ones", ones_count, 0);
        idle(2);

        // p = FF with all-ones words, then back-to-back run with all-zero words
        push4(4'b0000);
        start_run(8'hFF);
        for (int k = 0; k < 4; k++) send_word(8'hFF, -1, 0, -1);
        chk("t3_ones", ones_count, 0);
        push4(4'b1111);
        start_run(8'hFF);
        chk("t4_done_drop", done, 0);
        chk("t4_ones_clr", ones_count, 0);
        for (int k = 0; k < 4; k++) send_word(8'h00, -1, 0, -1);
        chk("t4_ones", ones_count, 4);
        idle(2);

        // Mid-word p_load takes effect on the next word
        push4(4'b0101);
        start_run(8'h00);
        send_word(8'h10, 3, 8'hFF, -1);
        send_word(8'h10, -1, 0, -1);
        send_word(8'hFF, -1, 0, -1);
        send_word(8'h00, -1, 0, -1);
        chk("t5_ones", ones_count, 2);
        idle(2);

        // p_load on the completion edge
        push4(4'b1010);
        start_run(8'h40);
        send_word(8'h20, 7, 8'h10, -1);
        send_word(8'h20, -1, 0, -1);
        send_word(8'h0F, -1, 0, -1);
        send_word(8'h10, -1, 0, -1);
        chk("t6_ones", ones_count, 2);
        idle(2);

        // start during RUN is ignored
        push4(4'b1111);
        start_run(8'h80);
        send_word(8'h00, -1, 0, -1);
        send_word(8'h00, -1, 0, 2);
        send_word(8'h00, -1, 0, -1);
        send_word(8'h00, -1, 0, -1);
        chk("t7_ones", ones_count, 4);
        chk("t7_done", done, 1);
        idle(2);

        // Asynchronous reset mid-word
        exp_q.push_back(1'b1);
        start_run(8'h80);
        send_word(8'h00, -1, 0, -1);
        idle(3);
        #2;
        RST = 1;
        #1;
        chk("arst_sbit", sbit, 0);
        chk("arst_valid", sbit_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ones", ones_count, 0);
        @(negedge CLK);
        RST = 0;
        idle(20);
        chk("arst_busy_after", busy, 0);

        chk("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stochastic_bitstream_gen.md
# stochastic_bitstream_gen

Converts the serial pseudorandom bit stream of `fibonacci_lfsr_64` into a stochastic bitstream of fixed length. It assembles WIDTH consecutive random bits into an unsigned random word and compares that word against a latched probability. It emits one stochastic bit per word and counts the ones. It sits directly downstream of the LFSR and feeds stochastic arithmetic units.

## Interface
- `WIDTH`, 8: random-word and probability width in bits; probability is `p / 2^WIDTH`.
- `STREAM_LEN`, 256: stochastic bits emitted per run; must be ≥1.
- `CNT_W`, `$clog2(STREAM_LEN+1)`: width of the counters.

- `CLK` in 1: clock; all state changes on its rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `r` in 1: serial random bit from the LFSR.
- `start` in 1: begin a run; sampled in IDLE or DONE, ignored in RUN.
- `p_in` in WIDTH: probability value.
- `p_load` in 1: request a probability update.
- `sbit` out 1: stochastic output bit; valid when `sbit_valid`=1.
- `sbit_valid` out 1: one-cycle pulse per emitted bit.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `ones_count` out CNT_W: ones emitted in the current or last run.

## Operation
- State machine states: IDLE, RUN, DONE.
  - Reset → IDLE.
  - IDLE/DONE + `start` → RUN.
  - RUN → DONE on the edge that emits bit number STREAM_LEN.
  - DONE holds until `start`.
- `rand_sr` (WIDTH-1 bits) shifts in `r` on every edge in every state: `rand_sr <= {rand_sr[WIDTH-3:0], r}`.
- On `start`:
  - `p_active <= p_in`, `pending <= 0`.
  - `bit_cnt`, `emit_cnt`, `ones_count` <= 0.
  - `start` wins over a simultaneous `p_load`.
- In RUN, `bit_cnt` increments every edge.
- Word completion: when `bit_cnt == WIDTH-1`:
  - `word = {rand_sr, r}`; the earliest-sampled bit is the MSB.
  - `sbit <= (word < p_active)`, `sbit_valid <= 1`.
  - `ones_count += sbit value`, `emit_cnt += 1`, `bit_cnt <= 0`.
- The comparison is unsigned.
  - `p_active = 0` gives all zeros.
  - `p_active = 2^WIDTH-1` gives a one except when the word is all-ones; probability 1.0 is not representable.
- `p_load` outside a `start` edge:
  - `p_shadow <= p_in`, `pending <= 1`; a later `p_load` before the boundary overwrites `p_shadow`.
  - If in IDLE or DONE, `p_active <= p_in` directly and `pending` stays 0.
  - In RUN, the pending value is copied to `p_active` on the next word-completion edge, after that word's comparison uses the old value. This includes a `p_load` on the completion edge itself.
- `sbit_valid` is 0 on all other edges. `sbit` holds its last value.
- `ones_count` never exceeds STREAM_LEN, so no overflow handling is needed. It holds its value in DONE until the next `start`.

## Timing
- Reset values:
  - Outputs `sbit`, `sbit_valid`, `busy`, `done`, `ones_count` = 0.
  - Internal `rand_sr`, `p_active`, `p_shadow`, `pending`, `bit_cnt`, `emit_cnt` = 0.
- `RST` clears everything immediately, independent of `CLK`, including mid-word and mid-run. No `sbit_valid` occurs after release until a new `start`.
- Start edge = E0. Word k uses `r` sampled at edges E(k·WIDTH-WIDTH+1) … E(k·WIDTH).
- `sbit_valid` for word k is high in the cycle following E(k·WIDTH). The first one comes WIDTH cycles after `start` is sampled.
- `busy` is high from the cycle after E0. `busy` falls and `done` rises in the same cycle as the final `sbit_valid`.
- Back-to-back runs: `start` in the first DONE cycle begins a new run on that edge. `done` drops the next cycle.

## Structure
- Package `stoch_pkg`:
  - typedef `stoch_state_t` enum {IDLE, RUN, DONE}.
  - Shared `localparam` helpers for CNT_W.
- Sub-module `serial_word_collector`:
  - Contains `rand_sr` and `bit_cnt`.
  - Outputs `word` and `word_ready`.
  - Controlled by `clear`/`enable` inputs.
- The top level holds the FSM, the probability registers and the counters.

## Test plan
- Stream of 4 words, WIDTH=8, STREAM_LEN=4, `p_in`=8'h80:
  - Stimulus: `r` drives words 8'h00, 8'hFF, 8'h7F, 8'h80 MSB-first.
  - Required: `sbit` = 1,0,1,0 on `sbit_valid` cycles 8, 16, 24, 32 after `start`; `ones_count`=2; `done`=1 with the 4th valid.
- Boundary probabilities:
  - `p_in`=0, `r` random → all `sbit`=0, `ones_count`=0.
  - `p_in`=8'hFF, `r` constant 1 → all 0.
  - `p_in`=8'hFF, `r` constant 0 → all 1, `ones_count`=4.
- Mid-word `p_load`:
  - Stimulus: `start` with p=8'h00; `p_load` 8'hFF at bit 3 of word 1; both words 8'h10.
  - Required: word 1 `sbit`=0, word 2 `sbit`=1.
- `p_load` on the completion edge → that word uses the old p; the next word uses the new p.
- `start` handling:
  - `start` pulsed in RUN → ignored; cycle timing unchanged.
  - `start` in DONE → counters cleared; new run's first valid arrives 8 cycles later.
- Reset and integration:
  - `RST` asserted between edges mid-word → outputs 0 immediately; no valid after release until `start`.
  - Connected to `fibonacci_lfsr_64` with WIDTH=16, STREAM_LEN=4096, p=16'h4000 → `ones_count` within 1024±96.
